// File: rtl/axi4_wr_burst_scheduler.sv
// Round-robin scheduler that shares one AXI4 write master among NUM_REQ requesters.
// W data follows grant order through a small order FIFO, and B responses are routed back by AWID.
module axi4_wr_burst_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DSIZE   = 64,
  parameter int ASIZE   = 32,
  parameter int LSIZE   = 8,
  parameter int IDSIZE  = 4,
  parameter int MAX_OUT = 8
) (
  input  logic                         axi_aclk,
  input  logic                         axi_areset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*ASIZE-1:0]     req_addr,
  input  logic [NUM_REQ*LSIZE-1:0]     req_len,
  input  logic [NUM_REQ*DSIZE-1:0]     s_wdata,
  input  logic [NUM_REQ-1:0]           s_wvalid,
  output logic [NUM_REQ-1:0]           s_wready,
  output logic [IDSIZE-1:0]            axi_awid,
  output logic [ASIZE-1:0]             axi_awaddr,
  output logic [LSIZE-1:0]             axi_awlen,
  output logic [1:0]                   axi_awburst,
  output logic                         axi_awvalid,
  input  logic                         axi_awready,
  output logic [DSIZE-1:0]             axi_wdata,
  output logic [DSIZE/8-1:0]           axi_wstrb,
  output logic                         axi_wlast,
  output logic                         axi_wvalid,
  input  logic                         axi_wready,
  input  logic [IDSIZE-1:0]            axi_bid,
  input  logic [1:0]                   axi_bresp,
  input  logic                         axi_bvalid,
  output logic                         axi_bready,
  output logic [NUM_REQ-1:0]           done_pulse,
  output logic [NUM_REQ-1:0]           err_pulse,
  output logic [$clog2(MAX_OUT):0]     outstanding
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int OW = $clog2(MAX_OUT) + 1;

  typedef enum logic {AW_IDLE, AW_SEND} aw_state_t;

  aw_state_t state_q, state_d;
  logic [IW-1:0]    last_grant_q, awidx_q, winner, head_idx;
  logic [ASIZE-1:0] awaddr_q;
  logic [LSIZE-1:0] awlen_q, head_len, beat_q, beat_d;
  logic [IW-1:0]    fifo_idx_q [MAX_OUT];
  logic [LSIZE-1:0] fifo_len_q [MAX_OUT];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [OW-1:0]    fifo_cnt_q, fifo_cnt_d, out_q, out_d;
  logic [NUM_REQ-1:0] done_q, done_d, err_q, err_d;
  logic [IW:0]      cand;
  logic             found, grant, w_active, w_hs, last_hs, b_dec;

  logic [ASIZE-1:0] addr_arr [NUM_REQ];
  logic [LSIZE-1:0] len_arr  [NUM_REQ];
  logic [DSIZE-1:0] data_arr [NUM_REQ];

  // First requesting index after last_grant, wrapping around.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_grant_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
      if (!found && req_valid[cand[IW-1:0]]) begin
        found  = 1'b1;
        winner = cand[IW-1:0];
      end
    end
  end

  assign grant = (state_q == AW_IDLE) && !axi_areset && (|req_valid) &&
                 (out_q < OW'(MAX_OUT)) && (fifo_cnt_q < OW'(MAX_OUT));

  // W is steered straight from the FIFO head; nothing moves while reset is held.
  assign w_active = (fifo_cnt_q != '0) && !axi_areset;
  assign head_idx = fifo_idx_q[rd_ptr_q];
  assign head_len = fifo_len_q[rd_ptr_q];
  assign axi_wvalid = w_active && s_wvalid[head_idx];
  assign axi_wdata  = w_active ? data_arr[head_idx] : '0;
  assign axi_wlast  = w_active && (beat_q == head_len);
  assign w_hs    = axi_wvalid && axi_wready;
  assign last_hs = w_hs && axi_wlast;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign addr_arr[gi]  = req_addr[gi*ASIZE +: ASIZE];
      assign len_arr[gi]   = req_len[gi*LSIZE +: LSIZE];
      assign data_arr[gi]  = s_wdata[gi*DSIZE +: DSIZE];
      assign req_ready[gi] = grant && (winner == IW'(gi));
      assign s_wready[gi]  = w_active && axi_wready && (head_idx == IW'(gi));
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    fifo_cnt_d = fifo_cnt_q;
    out_d      = out_q;
    done_d     = '0;
    err_d      = '0;
    case (state_q)
      AW_IDLE: if (grant) state_d = AW_SEND;
      AW_SEND: if (axi_awready) state_d = AW_IDLE;
      default: state_d = AW_IDLE;
    endcase
    if (last_hs)   beat_d = '0;
    else if (w_hs) beat_d = beat_q + 1'b1;
    if (grant && !last_hs)      fifo_cnt_d = fifo_cnt_q + 1'b1;
    else if (!grant && last_hs) fifo_cnt_d = fifo_cnt_q - 1'b1;
    b_dec = axi_bvalid && (out_q != '0);
    if (grant && !b_dec)      out_d = out_q + 1'b1;
    else if (!grant && b_dec) out_d = out_q - 1'b1;
    if (axi_bvalid && ({1'b0, axi_bid} < (IDSIZE+1)'(NUM_REQ))) begin
      done_d[axi_bid[IW-1:0]] = 1'b1;
      err_d[axi_bid[IW-1:0]]  = (axi_bresp != 2'b00);
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      state_q      <= AW_IDLE;
      last_grant_q <= IW'(NUM_REQ - 1);
      awidx_q      <= '0;
      awaddr_q     <= '0;
      awlen_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
      beat_q       <= '0;
      out_q        <= '0;
      done_q       <= '0;
      err_q        <= '0;
    end else begin
      state_q    <= state_d;
      fifo_cnt_q <= fifo_cnt_d;
      beat_q     <= beat_d;
      out_q      <= out_d;
      done_q     <= done_d;
      err_q      <= err_d;
      if (grant) begin
        last_grant_q <= winner;
        awidx_q      <= winner;
        awaddr_q     <= addr_arr[winner];
        awlen_q      <= len_arr[winner];
        wr_ptr_q     <= wr_ptr_q + 1'b1;
      end
      if (last_hs) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Order FIFO storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge axi_aclk) begin
    if (grant) begin
      fifo_idx_q[wr_ptr_q] <= winner;
      fifo_len_q[wr_ptr_q] <= len_arr[winner];
    end
  end

  assign axi_awvalid = (state_q == AW_SEND) && !axi_areset;
  assign axi_awid    = IDSIZE'(awidx_q);
  assign axi_awaddr  = awaddr_q;
  assign axi_awlen   = awlen_q;
  assign axi_awburst = 2'b01;
  assign axi_wstrb   = '1;
  assign axi_bready  = 1'b1;
  assign done_pulse  = done_q;
  assign err_pulse   = err_q;
  assign outstanding = out_q;
endmodule

// File: tb/tb_axi4_wr_burst_scheduler.sv
// Bench for axi4_wr_burst_scheduler: directed scenarios checked against a queue-based
// reference model on every cycle, plus literal expectations per scenario.
module tb_axi4_wr_burst_scheduler;
  localparam int N = 4, DW = 64, AW = 32, LW = 8, IDW = 4, MO = 8, OW = 4, DQ = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              axi_areset = 1'b1;
  logic [N-1:0]      req_valid, req_ready, s_wvalid, s_wready, done_pulse, err_pulse;
  logic [N*AW-1:0]   req_addr;
  logic [N*LW-1:0]   req_len;
  logic [N*DW-1:0]   s_wdata;
  logic [IDW-1:0]    axi_awid, axi_bid = '0;
  logic [AW-1:0]     axi_awaddr;
  logic [LW-1:0]     axi_awlen;
  logic [1:0]        axi_awburst, axi_bresp = '0;
  logic              axi_awvalid, axi_awready = 1'b1, axi_wlast, axi_wvalid, axi_wready = 1'b1;
  logic [DW-1:0]     axi_wdata;
  logic [DW/8-1:0]   axi_wstrb;
  logic              axi_bvalid = 1'b0, axi_bready;
  logic [OW-1:0]     outstanding;

  axi4_wr_burst_scheduler #(.NUM_REQ(N), .DSIZE(DW), .ASIZE(AW), .LSIZE(LW),
                            .IDSIZE(IDW), .MAX_OUT(MO)) dut (
    .axi_aclk(clk), .axi_areset(axi_areset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .s_wdata(s_wdata), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .done_pulse(done_pulse), .err_pulse(err_pulse), .outstanding(outstanding));

  int total = 0, bad = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Requester-side sources: descriptor lists and counting data streams.
  logic [AW-1:0] d_addr [N][DQ];
  logic [LW-1:0] d_len  [N][DQ];
  int d_n [N];
  int d_h [N];
  int src_cnt [N];
  logic flush = 1'b0;

  function automatic logic [DW-1:0] beat_data(input int i, input int n);
    return {28'hD000000, 4'(i), 32'(n)};
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_valid[i]         = d_h[i] < d_n[i];
      req_addr[i*AW +: AW] = d_addr[i][d_h[i] % DQ];
      req_len[i*LW +: LW]  = d_len[i][d_h[i] % DQ];
      s_wdata[i*DW +: DW]  = beat_data(i, src_cnt[i]);
    end
  end
  assign s_wvalid = '1;

  // Event logs of what the DUT actually did on its AXI side.
  int aw_cnt = 0, wl_cnt = 0;
  int aw_id_log [64];
  logic [AW-1:0] aw_addr_log [64];
  int wl_log [64];

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (flush) d_h[i] <= d_n[i];
      else if (req_valid[i] && req_ready[i]) d_h[i] <= d_h[i] + 1;
      if (s_wvalid[i] && s_wready[i]) src_cnt[i] <= src_cnt[i] + 1;
    end
    if (axi_awvalid && axi_awready) begin
      aw_id_log[aw_cnt]   <= int'(axi_awid);
      aw_addr_log[aw_cnt] <= axi_awaddr;
      aw_cnt <= aw_cnt + 1;
    end
    if (axi_wvalid && axi_wready && axi_wlast) begin
      wl_log[wl_cnt] <= int'(axi_wdata[35:32]);
      wl_cnt <= wl_cnt + 1;
    end
  end

  // Reference model: one pending AW offer, a queue of granted bursts, a credit count.
  int m_last = N - 1, m_hid = 0, m_beat = 0, m_out = 0;
  bit m_hold = 0, m_live = 0;
  logic [AW-1:0] m_haddr = '0;
  logic [LW-1:0] m_hlen = '0;
  int oq_idx [$];
  int oq_len [$];
  int m_wcnt [N];
  logic [N-1:0] m_done = '0, m_err = '0;

  always @(negedge clk) begin : model
    bit g, wact, e_wv, e_wl;
    int w, h;
    logic [N-1:0] e_rr, e_swr;
    g = 0; w = 0; h = 0; e_wv = 0; e_wl = 0; e_rr = '0; e_swr = '0;
    if (!m_hold && !axi_areset && req_valid != '0 && m_out < MO && oq_idx.size() < MO) begin
      for (int k = 1; k <= N; k++) begin
        if (!g && req_valid[(m_last + k) % N]) begin
          g = 1;
          w = (m_last + k) % N;
        end
      end
    end
    if (g) e_rr[w] = 1'b1;
    wact = (oq_idx.size() > 0) && !axi_areset;
    if (wact) begin
      h = oq_idx[0];
      e_wv = s_wvalid[h];
      e_swr[h] = axi_wready;
      e_wl = (m_beat == oq_len[0]);
    end
    if (m_live) begin
      chk("req_ready", req_ready, e_rr);
      chk("awvalid", axi_awvalid, m_hold && !axi_areset);
      if (m_hold) begin
        chk("awid", axi_awid, m_hid);
        chk("awaddr", axi_awaddr, m_haddr);
        chk("awlen", axi_awlen, m_hlen);
      end
      chk("wvalid", axi_wvalid, e_wv);
      chk("s_wready", s_wready, e_swr);
      if (wact) chk("wlast", axi_wlast, e_wl);
      if (e_wv) chk("wdata", axi_wdata, beat_data(h, m_wcnt[h]));
      chk("done", done_pulse, m_done);
      chk("err", err_pulse, m_err);
      chk("outstanding", outstanding, m_out);
      chk("consts", {axi_awburst, axi_wstrb, axi_bready}, {2'b01, 8'hFF, 1'b1});
    end
    if (e_wv && axi_wready) m_wcnt[h]++;
    if (axi_areset) begin
      m_live = 1; m_hold = 0; m_last = N - 1; m_beat = 0; m_out = 0;
      m_done = '0; m_err = '0;
      oq_idx.delete(); oq_len.delete();
    end else begin
      if (m_hold && axi_awready) m_hold = 0;
      if (g) begin
        m_hold = 1; m_hid = w; m_last = w;
        m_haddr = req_addr[w*AW +: AW];
        m_hlen  = req_len[w*LW +: LW];
        oq_idx.push_back(w);
        oq_len.push_back(int'(m_hlen));
      end
      if (e_wv && axi_wready) begin
        if (e_wl) begin
          void'(oq_idx.pop_front());
          void'(oq_len.pop_front());
          m_beat = 0;
        end else m_beat++;
      end
      m_out = m_out + (g ? 1 : 0) - ((axi_bvalid && m_out > 0) ? 1 : 0);
      m_done = '0; m_err = '0;
      if (axi_bvalid && axi_bid < N) begin
        m_done[axi_bid] = 1'b1;
        m_err[axi_bid]  = (axi_bresp != 2'b00);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    axi_areset = 1'b1; axi_bvalid = 1'b0; axi_awready = 1'b1; axi_wready = 1'b1;
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    step(1);
    axi_areset = 1'b0;
  endtask

  task automatic post(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l);
    d_addr[i][d_n[i] % DQ] = a;
    d_len[i][d_n[i] % DQ]  = l;
    d_n[i]++;
  endtask

  task automatic bpulse(input int id, input logic [1:0] resp);
    axi_bid = IDW'(id); axi_bresp = resp; axi_bvalid = 1'b1;
    step(1);
    axi_bvalid = 1'b0;
  endtask

  task automatic wait_wl(input int target, input int budget);
    for (int t = 0; t < budget && wl_cnt < target; t++) step(1);
    chk("wlast_wait", wl_cnt, target);
  endtask

  task automatic wait_aw(input int target, input int budget);
    for (int t = 0; t < budget && aw_cnt < target; t++) step(1);
    chk("aw_wait", aw_cnt, target);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ba, bw, b0, b1, b2, b3;
    do_reset();
    chk("rst_outstanding", outstanding, 0);
    chk("rst_awvalid", axi_awvalid, 0);
    chk("rst_wvalid", axi_wvalid, 0);

    // Single burst from requester 0.
    ba = aw_cnt; bw = wl_cnt; b0 = src_cnt[0];
    post(0, 32'h1000, 8'd3);
    wait_wl(bw + 1, 40);
    chk("t1_aw_count", aw_cnt - ba, 1);
    chk("t1_awid", aw_id_log[ba], 0);
    chk("t1_awaddr", aw_addr_log[ba], 32'h1000);
    chk("t1_beats", src_cnt[0] - b0, 4);
    bpulse(0, 2'b00);
    chk("t1_done", done_pulse, 4'b0001);
    chk("t1_out", outstanding, 0);
    step(1);
    chk("t1_done_gone", done_pulse, 4'b0000);

    // Contention: all four requesters at once.
    do_reset();
    ba = aw_cnt; bw = wl_cnt;
    post(0, 32'h2000, 8'd1); post(0, 32'h2100, 8'd0);
    post(1, 32'h3000, 8'd2); post(2, 32'h4000, 8'd0); post(3, 32'h5000, 8'd1);
    wait_wl(bw + 5, 100);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t2_grant%0d", k), aw_id_log[ba + k], k % 4);
      chk($sformatf("t2_wburst%0d", k), wl_log[bw + k], k % 4);
    end
    chk("t2_addr5", aw_addr_log[ba + 4], 32'h2100);

    // Credit limit with B held off.
    do_reset();
    ba = aw_cnt; bw = wl_cnt;
    post(0, 32'hA000, 0); post(0, 32'hA100, 0); post(0, 32'hA200, 0);
    post(1, 32'hB000, 0); post(1, 32'hB100, 0); post(1, 32'hB200, 0);
    post(2, 32'hC000, 0); post(2, 32'hC100, 0);
    post(3, 32'hD000, 0); post(3, 32'hD100, 0);
    step(40);
    chk("t3_aw8", aw_cnt - ba, 8);
    chk("t3_wl8", wl_cnt - bw, 8);
    chk("t3_out8", outstanding, 8);
    chk("t3_ready0", req_ready, 4'b0000);
    bpulse(0, 2'b00);
    chk("t3_out7", outstanding, 7);
    wait_aw(ba + 9, 10);
    chk("t3_ninth_id", aw_id_log[ba + 8], 0);
    chk("t3_ninth_addr", aw_addr_log[ba + 8], 32'hA200);
    step(1);
    chk("t3_out_back8", outstanding, 8);

    // Backpressure on AW and toggling W ready.
    do_reset();
    ba = aw_cnt; bw = wl_cnt; b1 = src_cnt[1]; b2 = src_cnt[2];
    axi_awready = 1'b0;
    post(1, 32'h6000, 8'd3); post(2, 32'h7000, 8'd2);
    for (int t = 0; t < 6; t++) begin
      axi_wready = ~axi_wready;
      step(1);
    end
    chk("t4_no_aw", aw_cnt - ba, 0);
    chk("t4_awvalid", axi_awvalid, 1);
    chk("t4_awaddr_held", axi_awaddr, 32'h6000);
    chk("t4_awlen_held", axi_awlen, 3);
    axi_awready = 1'b1;
    for (int t = 0; t < 30; t++) begin
      axi_wready = ~axi_wready;
      step(1);
    end
    axi_wready = 1'b1;
    step(2);
    chk("t4_aw2", aw_cnt - ba, 2);
    chk("t4_wl2", wl_cnt - bw, 2);
    chk("t4_beats1", src_cnt[1] - b1, 4);
    chk("t4_beats2", src_cnt[2] - b2, 3);

    // Error response and out-of-range ids.
    bpulse(2, 2'b10);
    chk("t5_done2", done_pulse, 4'b0100);
    chk("t5_err2", err_pulse, 4'b0100);
    chk("t5_out1", outstanding, 1);
    step(1);
    chk("t5_pulse_gone", {done_pulse, err_pulse}, 8'h00);
    bpulse(1, 2'b00);
    chk("t5_done1", done_pulse, 4'b0010);
    chk("t5_err_none", err_pulse, 4'b0000);
    bpulse(4, 2'b11);
    chk("t5_bid4_none", {done_pulse, err_pulse}, 8'h00);
    chk("t5_out_sat0", outstanding, 0);

    // Reset in the middle of a long burst.
    do_reset();
    ba = aw_cnt; bw = wl_cnt; b3 = src_cnt[3];
    post(3, 32'h8000, 8'd7);
    for (int t = 0; t < 40 && src_cnt[3] - b3 < 2; t++) step(1);
    chk("t6_two_beats", src_cnt[3] - b3, 2);
    axi_areset = 1'b1; flush = 1'b1;
    step(1);
    flush = 1'b0;
    chk("t6_rst_ready", {req_ready, s_wready}, 8'h00);
    chk("t6_rst_valid", {axi_awvalid, axi_wvalid, axi_wlast}, 3'b000);
    chk("t6_rst_pulses", {done_pulse, err_pulse}, 8'h00);
    chk("t6_rst_out", outstanding, 0);
    step(1);
    axi_areset = 1'b0;
    post(3, 32'h9000, 8'd1);
    wait_wl(bw + 1, 40);
    chk("t6_aw2", aw_cnt - ba, 2);
    chk("t6_fresh_addr", aw_addr_log[aw_cnt - 1], 32'h9000);
    chk("t6_fresh_burst", wl_log[bw], 3);
    chk("t6_beats_total", src_cnt[3] - b3, 4);
    chk("t6_out1", outstanding, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
